// File: rtl/core_pkg.sv
// Shared types for the load-use interlock: the shadow-pipe entry and helpers.
package core_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } shadow_entry_t;

  localparam shadow_entry_t BUBBLE_ENTRY = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

  // True when an in-flight entry is a load whose result an ID source needs.
  function automatic logic entry_blocks(
    input shadow_entry_t entry,
    input logic          use1,
    input logic [4:0]    src1,
    input logic          use2,
    input logic [4:0]    src2
  );
    logic pending_load;
    pending_load = entry.valid & entry.is_load & (entry.dest != REG_ZERO);
    return pending_load & ((use1 & (src1 == entry.dest)) | (use2 & (src2 == entry.dest)));
  endfunction

endpackage

// File: rtl/interlock_shadow_stage.sv
// One stage of the shadow pipe that follows instructions past ID.
module interlock_shadow_stage
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          bubble,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  // Advance unless held; a bubble request replaces the incoming entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE_ENTRY;
    end else if (!hold) begin
      q <= bubble ? BUBBLE_ENTRY : d;
    end
  end

endmodule

// File: rtl/load_use_interlock.sv
// Load-use interlock: stalls IF/ID and bubbles ID/EX while a load result is
// still out of forwarding reach, freezes on memory wait, squashes on flush.
module load_use_interlock
  import core_pkg::*;
#(
  parameter int LOAD_USE_GAP = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic             validID_pi,
  input  logic [4:0]       src1ID_pi,
  input  logic [4:0]       src2ID_pi,
  input  logic             use1ID_pi,
  input  logic             use2ID_pi,
  input  logic [4:0]       destID_pi,
  input  logic             weID_pi,
  input  logic             isLoadID_pi,
  input  logic             flushEX_pi,
  input  logic             memBusy_pi,
  output logic             stallIF_po,
  output logic             stallID_po,
  output logic             bubbleEX_po,
  output logic             freeze_po,
  output logic [CNT_W-1:0] stallCount_po
);

  shadow_entry_t            id_entry;
  shadow_entry_t            stage_in  [1:LOAD_USE_GAP];
  shadow_entry_t            stage_out [1:LOAD_USE_GAP];
  logic [LOAD_USE_GAP:1]    stage_match;
  logic                     hazard;
  logic                     insert_bubble;
  logic                     count_en;

  assign id_entry = '{valid: validID_pi & weID_pi, dest: destID_pi, is_load: isLoadID_pi};

  genvar k;
  generate
    for (k = 1; k <= LOAD_USE_GAP; k++) begin : g_shadow
      if (k == 1) begin : g_head
        assign stage_in[k] = id_entry;
      end else begin : g_tail
        assign stage_in[k] = stage_out[k-1];
      end

      interlock_shadow_stage u_stage (
        .clk    (clk_pi),
        .rst_n  (rst_n_pi),
        .hold   (memBusy_pi),
        .bubble ((k == 1) ? insert_bubble : 1'b0),
        .d      (stage_in[k]),
        .q      (stage_out[k])
      );

      assign stage_match[k] = entry_blocks(stage_out[k], use1ID_pi, src1ID_pi,
                                           use2ID_pi, src2ID_pi);
    end
  endgenerate

  assign hazard        = validID_pi & (|stage_match);
  assign insert_bubble = flushEX_pi | hazard;
  assign count_en      = ~memBusy_pi & ~flushEX_pi & hazard;

  // Priority mux: freeze beats flush beats load-use; everything is quiet in reset.
  always_comb begin
    stallIF_po  = 1'b0;
    stallID_po  = 1'b0;
    bubbleEX_po = 1'b0;
    freeze_po   = 1'b0;
    if (!rst_n_pi) begin
      freeze_po = 1'b0;
    end else if (memBusy_pi) begin
      freeze_po  = 1'b1;
      stallIF_po = 1'b1;
      stallID_po = 1'b1;
    end else if (flushEX_pi) begin
      bubbleEX_po = 1'b1;
    end else if (hazard) begin
      stallIF_po  = 1'b1;
      stallID_po  = 1'b1;
      bubbleEX_po = 1'b1;
    end
  end

  // Saturating count of load-use bubble cycles.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      stallCount_po <= '0;
    end else if (count_en && (stallCount_po != {CNT_W{1'b1}})) begin
      stallCount_po <= stallCount_po + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_use_interlock.sv
// Scoreboard bench: two interlocks (gap 1 with a 4-bit counter, gap 2 with a
// 16-bit counter) share one ID stream and are checked against a history model.
module tb_load_use_interlock;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        use1;
  logic        use2;
  logic [4:0]  dest;
  logic        we;
  logic        is_load;
  logic        flush;
  logic        busy;

  logic        stall_if_a, stall_id_a, bubble_a, freeze_a;
  logic [3:0]  count_a;
  logic        stall_if_b, stall_id_b, bubble_b, freeze_b;
  logic [15:0] count_b;

  int total = 0;
  int bad   = 0;

  load_use_interlock #(.LOAD_USE_GAP(1), .CNT_W(4)) dut_a (
    .clk_pi(clk), .rst_n_pi(rst_n), .validID_pi(valid),
    .src1ID_pi(src1), .src2ID_pi(src2), .use1ID_pi(use1), .use2ID_pi(use2),
    .destID_pi(dest), .weID_pi(we), .isLoadID_pi(is_load),
    .flushEX_pi(flush), .memBusy_pi(busy),
    .stallIF_po(stall_if_a), .stallID_po(stall_id_a), .bubbleEX_po(bubble_a),
    .freeze_po(freeze_a), .stallCount_po(count_a)
  );

  load_use_interlock #(.LOAD_USE_GAP(2), .CNT_W(16)) dut_b (
    .clk_pi(clk), .rst_n_pi(rst_n), .validID_pi(valid),
    .src1ID_pi(src1), .src2ID_pi(src2), .use1ID_pi(use1), .use2ID_pi(use2),
    .destID_pi(dest), .weID_pi(we), .isLoadID_pi(is_load),
    .flushEX_pi(flush), .memBusy_pi(busy),
    .stallIF_po(stall_if_b), .stallID_po(stall_id_b), .bubbleEX_po(bubble_b),
    .freeze_po(freeze_b), .stallCount_po(count_b)
  );

  // What entered EX on each advancing cycle, newest first.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } rec_t;

  // Expected controls are {freeze, stallIF, stallID, bubbleEX}.
  typedef struct packed {
    logic [3:0]  ctrl_a;
    logic [15:0] cnt_a;
    logic [3:0]  ctrl_b;
    logic [15:0] cnt_b;
  } exp_t;

  rec_t hist_a[$];
  rec_t hist_b[$];
  int   model_cnt_a = 0;
  int   model_cnt_b = 0;
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A load among the last 'gap' EX entries that the ID sources need.
  function automatic bit model_hazard(input rec_t h[$], input int gap);
    for (int k = 0; k < gap && k < h.size(); k++) begin
      if (h[k].valid && h[k].is_load && h[k].dest != 5'd0 &&
          ((use1 && src1 == h[k].dest) || (use2 && src2 == h[k].dest)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected outputs this cycle, then advance the model over the coming edge.
  task automatic model_step(input int which, output logic [3:0] ctrl, output int cnt_now);
    rec_t h[$];
    rec_t n;
    int   gap;
    int   maxc;
    int   cnt;
    if (which == 0) begin
      h = hist_a; gap = 1; maxc = 15; cnt = model_cnt_a;
    end else begin
      h = hist_b; gap = 2; maxc = 65535; cnt = model_cnt_b;
    end
    if (!rst_n) begin
      ctrl = 4'b0000;
      h.delete();
      cnt = 0;
      cnt_now = 0;
    end else begin
      cnt_now = cnt;
      if (busy) begin
        ctrl = 4'b1110;
      end else begin
        n = '0;
        if (flush) begin
          ctrl = 4'b0001;
        end else if (valid && model_hazard(h, gap)) begin
          ctrl = 4'b0111;
          if (cnt < maxc) cnt = cnt + 1;
        end else begin
          ctrl = 4'b0000;
          n.valid   = valid && we;
          n.dest    = dest;
          n.is_load = is_load;
        end
        h.push_front(n);
        while (h.size() > gap) void'(h.pop_back());
      end
    end
    if (which == 0) begin
      hist_a = h; model_cnt_a = cnt;
    end else begin
      hist_b = h; model_cnt_b = cnt;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue the expectation.
  task automatic apply_stimulus(input bit r, input bit v, input logic [4:0] s1, input bit u1,
                                input logic [4:0] s2, input bit u2, input logic [4:0] d,
                                input bit w, input bit ld, input bit f, input bit b);
    exp_t e;
    logic [3:0] ca, cb;
    int na, nb;
    @(posedge clk);
    #1;
    rst_n = r; valid = v; src1 = s1; use1 = u1; src2 = s2; use2 = u2;
    dest = d; we = w; is_load = ld; flush = f; busy = b;
    model_step(0, ca, na);
    model_step(1, cb, nb);
    e.ctrl_a = ca;
    e.cnt_a  = 16'(na);
    e.ctrl_b = cb;
    e.cnt_b  = 16'(nb);
    sb.push_back(e);
  endtask

  task automatic op_lw(input logic [4:0] rd, input logic [4:0] rs1);
    apply_stimulus(1, 1, rs1, 1, 5'd0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic op_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit f, input bit b);
    apply_stimulus(1, 1, rs1, 1, rs2, 1, rd, 1, 0, f, b);
  endtask

  task automatic op_lui(input logic [4:0] rd);
    apply_stimulus(1, 1, 5'd0, 0, 5'd0, 0, rd, 1, 0, 0, 0);
  endtask

  task automatic op_nop();
    apply_stimulus(1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("ctrl_gap1", {28'd0, freeze_a, stall_if_a, stall_id_a, bubble_a}, {28'd0, e.ctrl_a});
        check_output("count_gap1", {28'd0, count_a}, {16'd0, e.cnt_a});
        check_output("ctrl_gap2", {28'd0, freeze_b, stall_if_b, stall_id_b, bubble_b}, {28'd0, e.ctrl_b});
        check_output("count_gap2", {16'd0, count_b}, {16'd0, e.cnt_b});
      end
    end
  end

  // Directed scenarios, then random traffic, then drain the scoreboard.
  initial begin
    logic [4:0] pick [4];
    int waited;
    pick[0] = 5'd0; pick[1] = 5'd5; pick[2] = 5'd6; pick[3] = 5'd7;
    rst_n = 1'b0; valid = 1'b0; src1 = '0; src2 = '0; use1 = 1'b0; use2 = 1'b0;
    dest = '0; we = 1'b0; is_load = 1'b0; flush = 1'b0; busy = 1'b0;

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] back-to-back load-use");
    op_lw(5'd5, 5'd1);
    repeat (3) op_add(5'd6, 5'd5, 5'd1, 0, 0);

    $display("[TB] x0 destination and unused sources");
    op_lw(5'd0, 5'd1);
    repeat (2) op_add(5'd6, 5'd0, 5'd0, 0, 0);
    op_lw(5'd5, 5'd1);
    repeat (2) op_lui(5'd5);

    $display("[TB] flush beats hazard");
    op_lw(5'd5, 5'd1);
    op_add(5'd6, 5'd5, 5'd1, 1, 0);
    repeat (2) op_add(5'd6, 5'd5, 5'd1, 0, 0);

    $display("[TB] memory freeze with load in flight");
    op_lw(5'd5, 5'd1);
    repeat (3) op_add(5'd6, 5'd5, 5'd1, 1, 1);
    repeat (3) op_add(5'd6, 5'd5, 5'd1, 0, 0);

    $display("[TB] load, nop, dependent use");
    op_lw(5'd7, 5'd1);
    op_nop();
    repeat (2) op_add(5'd8, 5'd7, 5'd2, 0, 0);

    $display("[TB] counter saturation");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (40) op_lw(5'd5, 5'd5);
    @(negedge clk);
    check_output("saturated_gap1", {28'd0, count_a}, 32'd15);

    $display("[TB] reset during stall");
    op_lw(5'd5, 5'd1);
    apply_stimulus(0, 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
    repeat (2) op_add(5'd6, 5'd5, 5'd1, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      apply_stimulus(($urandom_range(0, 99) != 0),
                     ($urandom_range(0, 7) != 0),
                     pick[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                     pick[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                     pick[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 7) == 0));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_use_interlock.md
# load_use_interlock

Pipeline interlock controller for the 5-stage RV32I core, the producer-side counterpart of the EX-stage forwarding unit. It stalls IF/ID and injects bubbles into ID/EX whenever forwarding cannot cover a dependency: a load result that is not yet available. It tracks in-flight loads in its own shadow pipeline, freezes the core on data-memory wait, and squashes the ID instruction on a taken branch. It sits beside the ID stage and drives the IF/ID and ID/EX pipeline-register enables.

## Interface
- LOAD_USE_GAP, 1: number of stages beyond ID (EX, MEM, ...) in which a load's destination cannot be forwarded; range 1..3.
- CNT_W, 16: width of the stall statistics counter.
- clk_pi  in  1  core clock.
- rst_n_pi  in  1  reset. Asynchronous, active-low.
- validID_pi  in  1  ID stage holds a real instruction.
- src1ID_pi, src2ID_pi  in  5 each  source registers of the ID instruction.
- use1ID_pi, use2ID_pi  in  1 each  the ID instruction actually reads src1/src2.
- destID_pi  in  5  destination register of the ID instruction.
- weID_pi  in  1  the ID instruction writes the register file.
- isLoadID_pi  in  1  the ID instruction is a load.
- flushEX_pi  in  1  taken branch/jump resolved in EX this cycle.
- memBusy_pi  in  1  data memory not ready; whole pipeline must hold.
- stallIF_po  out  1  hold PC and IF/ID.
- stallID_po  out  1  hold ID instruction (IF/ID write disable).
- bubbleEX_po  out  1  load NOP into ID/EX.
- freeze_po  out  1  hold every pipeline register.
- stallCount_po  out  CNT_W  saturating count of load-use bubble cycles.

## Operation
- Shadow pipe S[1..LOAD_USE_GAP], each entry {valid, dest[4:0], isLoad}. S[1] mirrors the instruction in EX; S[k+1] is S[k] one cycle later.
- A match at stage k requires all of:
  - S[k].valid and S[k].isLoad, with S[k].dest != 0;
  - (use1ID_pi and src1ID_pi == S[k].dest) or (use2ID_pi and src2ID_pi == S[k].dest).
- hazard = validID_pi and a match at any k.
- Priority, highest first:
  - memBusy_pi: freeze_po=1, stallIF_po=1, stallID_po=1, bubbleEX_po=0. Shadow pipe, counter and flush all held. flushEX_pi is ignored; the core re-presents it after the freeze.
  - flushEX_pi: bubbleEX_po=1, stalls 0. The wrong-path ID instruction is discarded and S[1] gets a bubble.
  - hazard: stallIF_po=1, stallID_po=1, bubbleEX_po=1. S[1] gets a bubble and stallCount_po increments, saturating at all-ones.
  - Otherwise all outputs 0. S[1] <= {validID_pi & weID_pi, destID_pi, isLoadID_pi}.
- When not frozen, S[k+1] <= S[k] every cycle.
- Writes to x0 never create a hazard. Non-load writers never stall; forwarding covers them.
- Control outputs are combinational from shadow state and ID inputs. stallCount_po is registered.

## Timing
- Reset (async assert): shadow entries invalid, counter 0. While rst_n_pi is low, every output is forced to 0.
- Deassertion takes effect on the next clk_pi edge. A reset asserted mid-stall discards pending shadow entries; no stall survives reset.
- LOAD_USE_GAP=1 example:
  - lw x5 is in ID at cycle t.
  - A dependent add reads x5 in ID at t+1: hazard, one bubble.
  - t+2: add re-evaluates with S[1]=bubble and proceeds. It reaches EX at t+3 while lw is in WB.
  - Exactly one bubble per dependency.
- For LOAD_USE_GAP=N, the bubble count is N minus the distance already elapsed; the minimum is 0 once the load has left S[N].
- stallCount_po updates on the edge that ends the bubble cycle.

## Structure
- Shared package core_pkg:
  - REG_ZERO constant (5'd0);
  - shadow entry struct {valid, dest, isLoad};
  - bubble-entry constant.
- Sub-module interlock_shadow_stage: one register stage with hold and bubble-insert inputs, instantiated LOAD_USE_GAP times in a generate loop.
- Match, priority mux and counter live in the top.

## Test plan
- Load-use: lw x5 then add x6,x5,x1 back-to-back (GAP=1). Required: one cycle of stallIF/stallID/bubbleEX=1, stallCount_po 0->1, add issued next cycle.
- x0 and unused source: lw x0 then add x6,x0,x0; and lw x5 then lui x5 (use1=use2=0). Required: no stall in either case.
- Flush priority: hazard and flushEX_pi=1 in the same cycle. Required: bubbleEX_po=1, stallIF_po=stallID_po=0, counter unchanged.
- Freeze: memBusy_pi=1 for 3 cycles while a load sits in S[1]. Required: freeze_po=1 and stalls high throughout, bubbleEX_po=0, shadow held. Load-use bubble still occurs after release.
- GAP=2: lw x7, nop, add x8,x7. Required: one bubble. lw then immediate dependent use: two bubbles, counter +2.
- Saturation and reset: with CNT_W=4, force 20 hazards. Required: stallCount_po=15. Assert rst_n_pi mid-stall: all outputs 0 immediately, counter 0.
